// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I decode with one-entry ID/EX register,
// load-use stall, flush and illegal-opcode flagging.

package decode_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       alt_op;
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rd;
      logic       sel_imm_b;
      logic       sel_pc_a;
      logic       wb;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [2:0] comparison;
      logic       illegal;
   } id_ex_t;

endpackage

module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_alu_op,
   output logic            out_alt_op,
   output logic [4:0]      out_ra,
   output logic [4:0]      out_rb,
   output logic [4:0]      out_rd,
   output logic            out_sel_imm_b,
   output logic            out_sel_pc_a,
   output logic            out_wb,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_branch,
   output logic            out_jump,
   output logic [2:0]      out_comparison,
   output logic            out_illegal
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd_f;

   assign opc  = in_instr[6:0];
   assign f3   = in_instr[14:12];
   assign rs1  = in_instr[19:15];
   assign rs2  = in_instr[24:20];
   assign rd_f = in_instr[11:7];

   logic is_r;
   logic is_opi;
   logic is_ld;
   logic is_st;
   logic is_br;
   logic is_lui;
   logic is_auipc;
   logic is_jal;
   logic is_jalr;

   assign is_r     = (opc == OPC_R);
   assign is_opi   = (opc == OPC_OP_IMM);
   assign is_ld    = (opc == OPC_LOAD);
   assign is_st    = (opc == OPC_STORE);
   assign is_br    = (opc == OPC_BRANCH);
   assign is_lui   = (opc == OPC_LUI);
   assign is_auipc = (opc == OPC_AUIPC);
   assign is_jal   = (opc == OPC_JAL);
   assign is_jalr  = (opc == OPC_JALR);

   // Immediate formats, each sign-extended from instr[31] within 32 bits.
   logic signed [31:0] imm_i;
   logic signed [31:0] imm_s;
   logic signed [31:0] imm_b;
   logic signed [31:0] imm_u;
   logic signed [31:0] imm_j;

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

   id_ex_t             dec;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]    imm_d;
   logic               uses_ra;
   logic               uses_rb;
   logic               writes;

   // Opcode class decode; shifts keep the full I-imm, ALU takes the
   // shamt from its low bits (5 for RV32, 6 for RV64).
   always_comb begin
      dec     = '0;
      imm32   = '0;
      uses_ra = 1'b0;
      uses_rb = 1'b0;
      writes  = 1'b0;
      unique case (1'b1)
         is_r: begin
            dec.alu_op = f3;
            dec.alt_op = in_instr[30];
            uses_ra    = 1'b1;
            uses_rb    = 1'b1;
            writes     = 1'b1;
         end
         is_opi: begin
            imm32         = imm_i;
            dec.sel_imm_b = 1'b1;
            dec.alu_op    = f3;
            dec.alt_op    = (f3 == 3'd5) & in_instr[30];
            uses_ra       = 1'b1;
            writes        = 1'b1;
         end
         is_ld: begin
            imm32        = imm_i;
            dec.mem_read = 1'b1;
            uses_ra      = 1'b1;
            writes       = 1'b1;
         end
         is_st: begin
            imm32         = imm_s;
            dec.mem_write = 1'b1;
            uses_ra       = 1'b1;
            uses_rb       = 1'b1;
         end
         is_br: begin
            imm32          = imm_b;
            dec.branch     = 1'b1;
            dec.comparison = f3;
            uses_ra        = 1'b1;
            uses_rb        = 1'b1;
         end
         is_lui: begin
            imm32         = imm_u;
            dec.sel_imm_b = 1'b1;
            writes        = 1'b1;
         end
         is_auipc: begin
            imm32         = imm_u;
            dec.sel_pc_a  = 1'b1;
            dec.sel_imm_b = 1'b1;
            writes        = 1'b1;
         end
         is_jal: begin
            imm32         = imm_j;
            dec.jump      = 1'b1;
            dec.sel_pc_a  = 1'b1;
            dec.sel_imm_b = 1'b1;
            writes        = 1'b1;
         end
         is_jalr: begin
            imm32         = imm_i;
            dec.jump      = 1'b1;
            dec.sel_imm_b = 1'b1;
            uses_ra       = 1'b1;
            writes        = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      dec.ra = uses_ra ? rs1 : 5'd0;
      dec.rb = uses_rb ? rs2 : 5'd0;
      dec.rd = writes ? rd_f : 5'd0;
      dec.wb = writes & (rd_f != 5'd0);
   end

   assign imm_d = XLEN'(imm32);

   logic stall;
   logic hz_hit;
   logic accept;

   assign hz_hit = ex_mem_read & (ex_rd != 5'd0) &
                   ((uses_ra & (rs1 == ex_rd)) |
                    (uses_rb & (rs2 == ex_rd)));
   assign stall  = HAZARD_EN ? hz_hit : 1'b0;

   id_ex_t          q_ctl;
   logic [XLEN-1:0] q_pc;
   logic [XLEN-1:0] q_imm;
   logic            q_valid;

   assign in_ready = flush | (~stall & (~q_valid | out_ready));
   assign accept   = in_valid & in_ready & ~flush;

   // ID/EX register: flush clears, accept loads, drain leaves a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_ctl   <= '0;
         q_pc    <= '0;
         q_imm   <= '0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (accept) begin
         q_valid <= 1'b1;
         q_ctl   <= dec;
         q_pc    <= in_pc;
         q_imm   <= imm_d;
      end else if (out_ready) begin
         q_valid <= 1'b0;
      end
   end

   assign out_valid      = q_valid;
   assign out_pc         = q_pc;
   assign out_imm        = q_imm;
   assign out_alu_op     = q_ctl.alu_op;
   assign out_alt_op     = q_ctl.alt_op;
   assign out_ra         = q_ctl.ra;
   assign out_rb         = q_ctl.rb;
   assign out_rd         = q_ctl.rd;
   assign out_sel_imm_b  = q_ctl.sel_imm_b;
   assign out_sel_pc_a   = q_ctl.sel_pc_a;
   assign out_wb         = q_ctl.wb;
   assign out_mem_read   = q_ctl.mem_read;
   assign out_mem_write  = q_ctl.mem_write;
   assign out_branch     = q_ctl.branch;
   assign out_jump       = q_ctl.jump;
   assign out_comparison = q_ctl.comparison;
   assign out_illegal    = q_ctl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors, expectations queued at issue and
// checked by a monitor whenever the ID/EX register hands off.

module tb_decode_stage;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  alu_op;
      logic        alt_op;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rd;
      logic        sel_imm_b;
      logic        sel_pc_a;
      logic        wb;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic [2:0]  comparison;
      logic        illegal;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            ex_mem_read;
   logic [4:0]      ex_rd;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_alu_op;
   logic            out_alt_op;
   logic [4:0]      out_ra;
   logic [4:0]      out_rb;
   logic [4:0]      out_rd;
   logic            out_sel_imm_b;
   logic            out_sel_pc_a;
   logic            out_wb;
   logic            out_mem_read;
   logic            out_mem_write;
   logic            out_branch;
   logic            out_jump;
   logic [2:0]      out_comparison;
   logic            out_illegal;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .HAZARD_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_alu_op(out_alu_op), .out_alt_op(out_alt_op),
      .out_ra(out_ra), .out_rb(out_rb), .out_rd(out_rd),
      .out_sel_imm_b(out_sel_imm_b), .out_sel_pc_a(out_sel_pc_a),
      .out_wb(out_wb), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_branch(out_branch),
      .out_jump(out_jump), .out_comparison(out_comparison),
      .out_illegal(out_illegal)
   );

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t act();
      exp_t a;
      a.pc         = out_pc;
      a.imm        = out_imm;
      a.alu_op     = out_alu_op;
      a.alt_op     = out_alt_op;
      a.ra         = out_ra;
      a.rb         = out_rb;
      a.rd         = out_rd;
      a.sel_imm_b  = out_sel_imm_b;
      a.sel_pc_a   = out_sel_pc_a;
      a.wb         = out_wb;
      a.mem_read   = out_mem_read;
      a.mem_write  = out_mem_write;
      a.branch     = out_branch;
      a.jump       = out_jump;
      a.comparison = out_comparison;
      a.illegal    = out_illegal;
      return a;
   endfunction

   task automatic chk(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   task automatic chk_ex(input string name, input exp_t got, input exp_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Monitor: every handoff to EX must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (flush) begin
            if (out_valid && !out_ready && q.size() > 0)
               void'(q.pop_front());
         end else if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out got pc=%h want=none", out_pc);
            end else begin
               chk_ex("handoff", act(), q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic [31:0] pc,
                       input exp_t e);
      bit ok;
      ok       = 1'b0;
      in_instr = i;
      in_pc    = pc;
      in_valid = 1'b1;
      q.push_back(e);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL accept_timeout got in_ready=0 want=1 pc=%h", pc);
      end
      tick();
      in_valid = 1'b0;
   endtask

   exp_t e_st;
   exp_t e;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_instr    = '0;
      in_pc       = '0;
      flush       = 1'b0;
      ex_mem_read = 1'b0;
      ex_rd       = '0;
      out_ready   = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_valid", out_valid, 1'b0);
      chk_ex("reset_fields", act(), '0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // add x3,x1,x2 then load-use stall on x5
      in_instr = 32'h002081B3;
      in_pc    = 32'h100;
      in_valid = 1'b1;
      q.push_back('{pc:32'h100, ra:5'd1, rb:5'd2, rd:5'd3,
                    wb:1'b1, default:'0});
      @(negedge clk);
      chk("idle_ready", in_ready, 1'b1);
      tick();
      in_instr    = 32'h00528333;
      in_pc       = 32'h104;
      ex_mem_read = 1'b1;
      ex_rd       = 5'd5;
      @(negedge clk);
      chk("latency1_valid", out_valid, 1'b1);
      chk("stall_ready", in_ready, 1'b0);
      tick();
      @(negedge clk);
      chk("bubble_valid", out_valid, 1'b0);
      chk("stall_hold_ready", in_ready, 1'b0);
      tick();
      ex_mem_read = 1'b0;
      q.push_back('{pc:32'h104, ra:5'd5, rb:5'd5, rd:5'd6,
                    wb:1'b1, default:'0});
      @(negedge clk);
      chk("release_ready", in_ready, 1'b1);
      tick();

      // same instruction, load in EX targets x0: no stall
      ex_mem_read = 1'b1;
      ex_rd       = 5'd0;
      in_pc       = 32'h108;
      q.push_back('{pc:32'h108, ra:5'd5, rb:5'd5, rd:5'd6,
                    wb:1'b1, default:'0});
      @(negedge clk);
      chk("rd0_nostall", in_ready, 1'b1);
      tick();

      // sw x0,8(x0): store rd field equals ex_rd, must not stall
      ex_rd    = 5'd8;
      in_instr = 32'h00002423;
      in_pc    = 32'h10C;
      e_st     = '{pc:32'h10C, imm:32'h8, mem_write:1'b1, default:'0};
      q.push_back(e_st);
      @(negedge clk);
      chk("store_nostall", in_ready, 1'b1);
      tick();
      ex_mem_read = 1'b0;
      ex_rd       = 5'd0;

      // backpressure: held store, new addi offered for 3 cycles
      out_ready = 1'b0;
      in_instr  = 32'hFFF00093;
      in_pc     = 32'h110;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_ready", in_ready, 1'b0);
         chk("hold_valid", out_valid, 1'b1);
         chk_ex("hold_fields", act(), e_st);
         tick();
      end
      out_ready = 1'b1;
      q.push_back('{pc:32'h110, imm:32'hFFFFFFFF, rd:5'd1,
                    sel_imm_b:1'b1, wb:1'b1, default:'0});
      @(negedge clk);
      chk("unhold_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;

      e = '{pc:32'h114, imm:32'hFFF00000, rd:5'd1, sel_imm_b:1'b1,
            sel_pc_a:1'b1, wb:1'b1, jump:1'b1, default:'0};
      send(32'h800000EF, 32'h114, e);
      e = '{pc:32'h118, alt_op:1'b1, ra:5'd1, rb:5'd2, rd:5'd3,
            wb:1'b1, default:'0};
      send(32'h402081B3, 32'h118, e);
      e = '{pc:32'h11C, imm:32'h403, alu_op:3'd5, alt_op:1'b1, ra:5'd6,
            rd:5'd5, sel_imm_b:1'b1, wb:1'b1, default:'0};
      send(32'h40335293, 32'h11C, e);
      e = '{pc:32'h120, imm:32'h8, ra:5'd1, rb:5'd2, branch:1'b1,
            comparison:3'd1, default:'0};
      send(32'h00209463, 32'h120, e);
      e = '{pc:32'h124, imm:32'h1000, rd:5'd10, sel_imm_b:1'b1,
            sel_pc_a:1'b1, wb:1'b1, default:'0};
      send(32'h00001517, 32'h124, e);
      e = '{pc:32'h128, sel_imm_b:1'b1, default:'0};
      send(32'h00000013, 32'h128, e);
      e = '{pc:32'h12C, imm:32'h12345000, rd:5'd7, sel_imm_b:1'b1,
            wb:1'b1, default:'0};
      send(32'h123453B7, 32'h12C, e);
      e = '{pc:32'h130, imm:32'h4, ra:5'd2, rd:5'd9, mem_read:1'b1,
            wb:1'b1, default:'0};
      send(32'h00412483, 32'h130, e);

      // flush with held lw, stalling incoming add x6,x2,x2
      out_ready   = 1'b0;
      flush       = 1'b1;
      ex_mem_read = 1'b1;
      ex_rd       = 5'd2;
      in_instr    = 32'h00210333;
      in_pc       = 32'h134;
      in_valid    = 1'b1;
      @(negedge clk);
      chk("flush_ready", in_ready, 1'b1);
      tick();
      flush       = 1'b0;
      in_valid    = 1'b0;
      ex_mem_read = 1'b0;
      ex_rd       = 5'd0;
      @(negedge clk);
      chk("flush_clear", out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("flush_discard", out_valid, 1'b0);
      tick();
      out_ready = 1'b1;

      e = '{pc:32'h200, illegal:1'b1, default:'0};
      send(32'h0000007F, 32'h200, e);

      for (int k = 0; k < 10; k++) begin
         if (q.size() == 0)
            break;
         @(negedge clk);
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d want=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I-capable decode stage that sits between fetch and execute.
- Accepts one instruction plus PC per valid/ready handshake and decodes the full base integer opcode set (R, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR).
- Holds the result in a one-entry ID/EX output register.
- Adds load-use hazard stalling, pipeline flush and illegal-instruction flagging.

Parameters:
- XLEN, 32, datapath width of pc and imm; legal values 32 or 64.
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 ties the stall to 0.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch offers in_instr/in_pc
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  kill held and incoming instruction
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes this cycle
- out_pc  out  XLEN  registered pc
- out_imm  out  XLEN  sign-extended immediate
- out_alu_op  out  3  funct3-coded ALU op (0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and)
- out_alt_op  out  1  sub/sra select
- out_ra, out_rb, out_rd  out  5 each  register indices
- out_sel_imm_b  out  1  ALU B operand = imm
- out_sel_pc_a  out  1  ALU A operand = pc
- out_wb  out  1  register writeback
- out_mem_read  out  1  load
- out_mem_write  out  1  store
- out_branch  out  1  conditional branch
- out_jump  out  1  JAL/JALR
- out_comparison  out  3  branch funct3
- out_illegal  out  1  undecodable opcode

Behaviour:
- **Reset** (rst_n=0 at a clock edge): out_valid=0 and every out_* field=0. Reset mid-transfer drops the held instruction. in_ready is combinational and is 1 during reset only if its equation allows it.
- **Handshake:**
  - stall = HAZARD_EN & ex_mem_read & (ex_rd!=0) & ((uses_ra & ra==ex_rd) | (uses_rb & rb==ex_rd)), evaluated on in_instr.
  - in_ready = flush | (!stall & (!out_valid | out_ready)).
  - Accept = in_valid & in_ready & !flush. On accept, the register loads the decoded fields and out_valid=1 the next cycle: latency 1.
- **Drain without accept:** if out_ready=1 with no accept, out_valid→0 (bubble inserted on stall). If out_ready=0 and no accept, all outputs hold.
- **Flush:** takes priority over everything else. Next cycle out_valid=0, and any instruction offered that cycle is consumed and discarded. Flush concurrent with stall still clears.
- **Decode** (opcode=instr[6:0], f3=instr[14:12]):
  - The immediate is always sign-extended from instr[31] to XLEN.
  - R 0110011: alu_op=f3, alt_op=instr[30], uses ra, rb.
  - OP-IMM 0010011: I-imm, sel_imm_b=1, alu_op=f3, alt_op=instr[30] only when f3=5. For XLEN=32 the shamt is instr[24:20]; for XLEN=64 it is instr[25:20].
  - LOAD 0000011: I-imm, add, mem_read=1.
  - STORE 0100011: S-imm, add, mem_write=1, rd=0.
  - BRANCH 1100011: B-imm, branch=1, comparison=f3, rd=0, uses ra, rb.
  - LUI 0110111: U-imm, ra=0, add, sel_imm_b=1.
  - AUIPC 0010111: U-imm, sel_pc_a=1, sel_imm_b=1, add.
  - JAL 1101111: J-imm, jump=1, sel_pc_a=1, sel_imm_b=1.
  - JALR 1100111: I-imm, jump=1, sel_imm_b=1, uses ra.
  - Register indices: ra=instr[19:15] when used, else 0. rb=instr[24:20] when used, else 0. rd=instr[11:7] for writing classes, else 0.
  - wb = writing class & (rd!=0).
  - Any other opcode: illegal=1, all control fields 0, wb=0. This is not a stall.
- **Non-writing classes** (STORE, BRANCH) never trigger a hazard on rd.

Test Plan:
- Reset then in_instr=0x002081B3 (add x3,x1,x2), in_valid=1, out_ready=1 → one cycle later out_valid=1, ra=1, rb=2, rd=3, alu_op=0, alt_op=0, wb=1.
- ex_mem_read=1, ex_rd=5, in_instr=0x00528333 (add x6,x5,x5) → in_ready=0; out_valid→0 next cycle. Releasing ex_mem_read → accepted. Same test with ex_rd=0 → no stall.
- out_ready=0 with a held instruction and a new in_valid → in_ready=0, outputs unchanged for 3 cycles, then out_ready=1 → new instruction loaded next cycle.
- in_instr=0xFFF00093 (addi x1,x0,-1) → imm=0xFFFFFFFF (XLEN=64: all ones), sel_imm_b=1. Then 0x800000EF (jal x1,-1MiB) → imm=0xFFF00000, jump=1, wb=1.
- flush=1 while out_valid=1 and in_valid=1 with out_ready=0 → in_ready=1, next cycle out_valid=0. Opcode 0x7F → illegal=1, wb=0, mem_read=0.
